// File: rtl/hwag_sync.sv
// Crank-wheel synchroniser for an N-M trigger wheel. It measures tooth periods, finds the
// missing-tooth gap, and tracks the tooth number and sync state.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_STOP   | idle; pcnt held at 0, waiting for the first active edge
// ST_SEARCH | measuring teeth, looking for the short-long-short gap pattern
// ST_SYNC   | locked; tooth_num tracks position, gap verified every rev
module hwag_sync #(
  parameter int PCNT_WIDTH    = 24,
  parameter int TCNT_WIDTH    = 6,
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int GAP_SHIFT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cap,
  input  logic                  cap_edge_sel,
  input  logic                  err_clr,
  output logic                  sync,
  output logic [TCNT_WIDTH-1:0] tooth_num,
  output logic [PCNT_WIDTH-1:0] tooth_period,
  output logic                  tooth_strobe,
  output logic                  gap_strobe,
  output logic                  err_gap_lost,
  output logic                  err_gap_early,
  output logic                  err_stall
);

  localparam logic [TCNT_WIDTH-1:0] LAST_TOOTH = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING - 1);
  localparam logic [PCNT_WIDTH-1:0] PCNT_MAX   = '1;

  typedef enum logic [1:0] {ST_STOP, ST_SEARCH, ST_SYNC} state_t;

  state_t                state;
  logic                  cap_s1, cap_s2, cap_d, sel_q;
  logic                  act_edge;
  logic [PCNT_WIDTH-1:0] pcnt, h1, h2;
  logic [1:0]            hcnt;
  logic [PCNT_WIDTH-1:0] p_meas, h1_sh, p_sh;
  logic                  gap_search, gap_sync, overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
      cap_d  <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      cap_s1 <= cap;
      cap_s2 <= cap_s1;
      cap_d  <= cap_s2;
      sel_q  <= cap_edge_sel;
    end
  end

  assign act_edge = sel_q ? (cap_d & ~cap_s2) : (cap_s2 & ~cap_d);

  // Period of the tooth ending on this edge, and the gap tests on pre-shift history.
  assign p_meas     = pcnt + PCNT_WIDTH'(1);
  assign h1_sh      = h1 >> GAP_SHIFT;
  assign p_sh       = p_meas >> GAP_SHIFT;
  assign gap_search = (hcnt >= 2'd2) && (p_meas < h1_sh) && (h2 < h1_sh);
  assign gap_sync   = (h1 < p_sh);
  assign overflow   = (state != ST_STOP) && (pcnt == PCNT_MAX);

  // Only two history entries feed any decision, so older periods are not stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_STOP;
      pcnt          <= '0;
      h1            <= '0;
      h2            <= '0;
      hcnt          <= 2'd0;
      sync          <= 1'b0;
      tooth_num     <= '0;
      tooth_period  <= '0;
      tooth_strobe  <= 1'b0;
      gap_strobe    <= 1'b0;
      err_gap_lost  <= 1'b0;
      err_gap_early <= 1'b0;
      err_stall     <= 1'b0;
    end else begin
      tooth_strobe <= 1'b0;
      gap_strobe   <= 1'b0;
      if (err_clr) begin
        err_gap_lost  <= 1'b0;
        err_gap_early <= 1'b0;
        err_stall     <= 1'b0;
      end

      // Disable and overflow both drop to STOP; an edge coinciding with overflow is lost.
      if (!ena || overflow) begin
        if (ena) err_stall <= 1'b1;
        state        <= ST_STOP;
        pcnt         <= '0;
        h1           <= '0;
        h2           <= '0;
        hcnt         <= 2'd0;
        sync         <= 1'b0;
        tooth_num    <= '0;
        tooth_period <= '0;
      end else if (act_edge) begin
        pcnt <= '0;
        if (state != ST_STOP) begin
          h2           <= h1;
          h1           <= p_meas;
          tooth_strobe <= 1'b1;
          if (hcnt != 2'd3) hcnt <= hcnt + 2'd1;
        end
        case (state)
          ST_STOP: state <= ST_SEARCH;
          ST_SEARCH: begin
            tooth_period <= p_meas;
            if (gap_search) begin
              state     <= ST_SYNC;
              sync      <= 1'b1;
              tooth_num <= TCNT_WIDTH'(1);
            end
          end
          ST_SYNC: begin
            if (!(tooth_num == LAST_TOOTH && gap_sync)) tooth_period <= p_meas;
            if (tooth_num == LAST_TOOTH) begin
              if (gap_sync) begin
                tooth_num  <= '0;
                gap_strobe <= 1'b1;
              end else begin
                err_gap_lost <= 1'b1;
                state        <= ST_SEARCH;
                sync         <= 1'b0;
                tooth_num    <= '0;
              end
            end else if (gap_sync) begin
              err_gap_early <= 1'b1;
              state         <= ST_SEARCH;
              sync          <= 1'b0;
              tooth_num     <= '0;
            end else begin
              tooth_num <= tooth_num + TCNT_WIDTH'(1);
            end
          end
          default: state <= ST_STOP;
        endcase
      end else if (state != ST_STOP) begin
        pcnt <= pcnt + PCNT_WIDTH'(1);
      end
    end
  end

endmodule
